multiplier_arbiter_16_bit: RTL and testbench
============================================

Name: multiplier_arbiter_16_bit

Overview:
- Shares one combinational 16x16 unsigned multiplier between NUM_REQ requesters.
- Uses round-robin arbitration, a two-stage pipeline (operand register, then result register), and valid/ready handshakes on both sides.
- Returns each product tagged with the requester index.
- Sits between the DSP-style client blocks and the team's existing 16-bit array multiplier, which it instantiates.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8
ID_W, $clog2(NUM_REQ), width of the requester tag (derived, not overridden)

Ports:
Clock_In  input  1  single clock, rising edge
Reset_N_In  input  1  synchronous, active-low reset
Req_Valid_In  input  NUM_REQ  per-requester request valid
Req_Data_A_In  input  NUM_REQ*16  operand A; requester i at bits [16i+15:16i]
Req_Data_B_In  input  NUM_REQ*16  operand B; same packing as A
Req_Ready_Out  output  NUM_REQ  per-requester accept; at most one bit high
Resp_Valid_Out  output  1  result valid
Resp_Ready_In  input  1  downstream accept
Resp_Result_Out  output  32  unsigned product A*B
Resp_Id_Out  output  ID_W  index of the requester that issued the result
Busy_Out  output  1  high while either pipeline stage holds data

Behaviour:
- Reset (Reset_N_In low at a rising edge):
  - S1 and S2 valid flags cleared; in-flight operations discarded, no response issued.
  - Round-robin pointer set to 0.
  - Resp_Valid_Out=0, Resp_Result_Out=0, Resp_Id_Out=0, Busy_Out=0.
  - Req_Ready_Out forced to 0 while Reset_N_In is low.
- Arbitration (combinational):
  - Grant goes to the first asserted Req_Valid_In searching upward from the pointer, wrapping modulo NUM_REQ.
  - Req_Ready_Out[g] = grant[g] AND s1_can_load; all other bits 0.
- Pointer update: on an accepted handshake from requester g, pointer <= (g+1) mod NUM_REQ. Unchanged otherwise.
- Stage advance rules:
  - s2_can_load = !S2_valid OR Resp_Ready_In.
  - s1_can_load = !S1_valid OR s2_can_load.
- Accept (Req_Valid_In[g] & Req_Ready_Out[g] at edge t): S1 captures A, B, and g; S1_valid=1.
- S1 to S2: when S1_valid & s2_can_load, S2 captures product of S1 A*B (full 32-bit, unsigned, no truncation) and S1 id; S2_valid=1.
- Latency: accepted at edge t produces Resp_Valid_Out high after edge t+1 (2-cycle latency). Throughput is one result per cycle while Resp_Ready_In stays high.
- Backpressure:
  - While Resp_Valid_Out=1 and Resp_Ready_In=0, Resp_Result_Out and Resp_Id_Out are held stable.
  - S1 holds its contents; if S1 is full, every Req_Ready_Out bit is 0.
- Drain: Resp_Valid_Out & Resp_Ready_In with no S1 data clears S2_valid. Simultaneous drain and S1->S2 transfer keeps S2_valid=1 with the new data.
- Requester rules: requesters hold valid and data stable until accepted. Req_Ready_Out may depend on Req_Valid_In; Req_Valid_In must not depend on Req_Ready_Out.
- Busy_Out = S1_valid | S2_valid, registered-state derived.
- A requester deasserting valid before grant is legal and simply loses its turn; the pointer is unaffected.

Decomposition:
- Shared package mult_arb_pkg:
  - OPERAND_W=16, PRODUCT_W=32.
  - Typedef mult_op_t {A, B, id}.
  - Typedef mult_resp_t {result, id}.
- Sub-module rr_arbiter_n: parameter N. Inputs req vector, pointer, advance. Outputs one-hot grant and index, plus registered pointer.
- Multiplier: instance of the existing 16-bit multiplier, inside the top level, between S1 and S2.

Test Plan:
- Reset then single request: Req_Valid_In=0001, A=0x0003, B=0x0005, Resp_Ready_In=1 -> accepted at edge t; Resp_Valid_Out=1 after edge t+1 with Result=0x0000000F, Id=0; Busy_Out returns to 0 afterwards.
- Boundary operands: A=0xFFFF, B=0xFFFF -> 0xFFFE0001. Then A=0x0000, B=0x1234 -> 0x00000000.
- All four requesters valid continuously with distinct operands -> grants in order 0,1,2,3,0. One result per cycle, Ids match grant order, no requester starved.
- Backpressure: hold Resp_Ready_In=0 for 5 cycles with 3 requests pending -> Resp outputs stable. Exactly one extra operation sits in S1, all Req_Ready_Out=0. On release, results drain in order with no loss or duplication.
- Pointer behaviour: requester 2 accepted, then only requesters 1 and 3 valid -> 3 granted before 1.
- Reset mid-operation: assert Reset_N_In=0 with S1 and S2 full -> next cycle Resp_Valid_Out=0, Busy_Out=0. No stale response after release; the next grant starts from requester 0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared widths and transaction types for the shared-multiplier arbiter.
package mult_arb_pkg;
  localparam int OPERAND_W = 16;
  localparam int PRODUCT_W = 32;
  localparam int MAX_ID_W  = 3;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic [MAX_ID_W-1:0]  id;
  } mult_op_t;

  typedef struct packed {
    logic [PRODUCT_W-1:0] result;
    logic [MAX_ID_W-1:0]  id;
  } mult_resp_t;
endpackage

// File: rtl/array_mult_16.sv
// Existing combinational 16x16 unsigned multiplier, full 32-bit product.
module array_mult_16
  import mult_arb_pkg::*;
(
  input  logic [OPERAND_W-1:0] a_i,
  input  logic [OPERAND_W-1:0] b_i,
  output logic [PRODUCT_W-1:0] p_o
);
  assign p_o = {{(PRODUCT_W-OPERAND_W){1'b0}}, a_i} * {{(PRODUCT_W-OPERAND_W){1'b0}}, b_i};
endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: searches upward from the pointer, pointer moves past the winner on advance.
module rr_arbiter_n #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o
);
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] j;

  // Scan from the farthest offset down so the nearest requester above the pointer wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    j       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr_q) + k) % N);
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (idx_o == W'(N - 1)) ? '0 : idx_o + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/multiplier_arbiter_16_bit.sv
// Shares one 16x16 multiplier among NUM_REQ requesters through a two-stage
// elastic pipeline (operand register, result register) with round-robin grant.
module multiplier_arbiter_16_bit
  import mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         Clock_In,
  input  logic                         Reset_N_In,
  input  logic [NUM_REQ-1:0]           Req_Valid_In,
  input  logic [NUM_REQ*OPERAND_W-1:0] Req_Data_A_In,
  input  logic [NUM_REQ*OPERAND_W-1:0] Req_Data_B_In,
  output logic [NUM_REQ-1:0]           Req_Ready_Out,
  output logic                         Resp_Valid_Out,
  input  logic                         Resp_Ready_In,
  output logic [PRODUCT_W-1:0]         Resp_Result_Out,
  output logic [ID_W-1:0]              Resp_Id_Out,
  output logic                         Busy_Out
);
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 accept;
  logic                 s1_can_load, s2_can_load;
  logic [PRODUCT_W-1:0] product;

  mult_op_t   s1_q, s1_d;
  mult_resp_t s2_q, s2_d;
  logic       s1_vld_q, s1_vld_d;
  logic       s2_vld_q, s2_vld_d;

  assign s2_can_load   = !s2_vld_q || Resp_Ready_In;
  assign s1_can_load   = !s1_vld_q || s2_can_load;
  assign Req_Ready_Out = grant & {NUM_REQ{s1_can_load & Reset_N_In}};
  assign accept        = |(Req_Valid_In & Req_Ready_Out);

  rr_arbiter_n #(.N(NUM_REQ)) u_arb (
    .clk_i     (Clock_In),
    .rst_ni    (Reset_N_In),
    .req_i     (Req_Valid_In),
    .advance_i (accept),
    .grant_o   (grant),
    .idx_o     (grant_idx)
  );

  // Stage 1: capture the granted requester's operands
  always_comb begin
    s1_d     = s1_q;
    s1_vld_d = s1_vld_q;
    if (accept) begin
      s1_d.a   = Req_Data_A_In[grant_idx*OPERAND_W +: OPERAND_W];
      s1_d.b   = Req_Data_B_In[grant_idx*OPERAND_W +: OPERAND_W];
      s1_d.id  = MAX_ID_W'(grant_idx);
      s1_vld_d = 1'b1;
    end else if (s2_can_load) begin
      s1_vld_d = 1'b0;
    end
  end

  array_mult_16 u_mult (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .p_o (product)
  );

  // Stage 2: register the product; holds while downstream stalls
  always_comb begin
    s2_d     = s2_q;
    s2_vld_d = s2_vld_q;
    if (s2_can_load) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_d.result = product;
        s2_d.id     = s1_q.id;
      end
    end
  end

  always_ff @(posedge Clock_In) begin
    if (!Reset_N_In) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  always_ff @(posedge Clock_In) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  // Data registers are not reset, so outputs are gated to read zero when empty.
  assign Resp_Valid_Out  = s2_vld_q;
  assign Resp_Result_Out = s2_vld_q ? s2_q.result : '0;
  assign Resp_Id_Out     = s2_vld_q ? s2_q.id[ID_W-1:0] : '0;
  assign Busy_Out        = s1_vld_q | s2_vld_q;

  if (ID_W < MAX_ID_W) begin : g_id_hi
    logic unused_id_hi;
    assign unused_id_hi = ^s2_q.id[MAX_ID_W-1:ID_W];
  end
endmodule

// File: tb/tb_multiplier_arbiter_16_bit.sv
// Randomised and directed bench for multiplier_arbiter_16_bit against a queue-based reference model.
module tb_multiplier_arbiter_16_bit;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    vld = '0;
  logic [N*16-1:0] da = '0;
  logic [N*16-1:0] db = '0;
  logic [N-1:0]    rdy;
  logic            rv;
  logic            rr = 1'b1;
  logic [31:0]     res;
  logic [1:0]      rid;
  logic            busy;

  always #5 clk = ~clk;

  multiplier_arbiter_16_bit #(.NUM_REQ(N)) dut (
    .Clock_In        (clk),
    .Reset_N_In      (rst_n),
    .Req_Valid_In    (vld),
    .Req_Data_A_In   (da),
    .Req_Data_B_In   (db),
    .Req_Ready_Out   (rdy),
    .Resp_Valid_Out  (rv),
    .Resp_Ready_In   (rr),
    .Resp_Result_Out (res),
    .Resp_Id_Out     (rid),
    .Busy_Out        (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: in-flight items in order, each tagged with the edge it was accepted on.
  typedef struct {
    logic [31:0] prod;
    int          id;
    int          edge_no;
  } item_t;

  item_t       sbq[$];
  int          ptr = 0;
  int          cyc = 0;
  int          acc_id = -1;
  int          n_resp = 0;
  logic        rst_done = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res;
  logic [1:0]  prev_id;
  int          m_g;
  int          m_a;
  logic [N-1:0] m_exp_rdy;
  logic        m_exp_rv;
  item_t       m_it;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    acc_id = -1;
    if (!rst_n) begin
      check("rdy_in_reset", rdy, '0);
      if (rst_done) begin
        check("rst_resp_valid", rv, 0);
        check("rst_busy", busy, 0);
        check("rst_result", res, 0);
        check("rst_id", rid, 0);
      end
      sbq.delete();
      ptr = 0;
      prev_hold = 1'b0;
      rst_done = 1'b1;
    end else begin
      rst_done = 1'b0;
      m_exp_rv = (sbq.size() != 0) && (cyc >= sbq[0].edge_no + 1);
      check("resp_valid", rv, m_exp_rv);
      check("busy", busy, sbq.size() != 0);
      if (prev_hold) begin
        check("hold_result", res, prev_res);
        check("hold_id", rid, prev_id);
      end
      if (rv && m_exp_rv) begin
        check("result", res, sbq[0].prod);
        check("resp_id", rid, sbq[0].id);
      end
      check("ready_onehot", $countones(rdy) <= 1, 1);
      m_g = rr_pick(vld, ptr);
      m_exp_rdy = '0;
      if (m_g >= 0 && (sbq.size() < 2 || rr)) m_exp_rdy[m_g] = 1'b1;
      check("req_ready", rdy, m_exp_rdy);
      prev_hold = rv && !rr;
      prev_res = res;
      prev_id = rid;
      if (rv && rr && sbq.size() != 0) begin
        void'(sbq.pop_front());
        n_resp++;
      end
      m_a = -1;
      for (int i = 0; i < N; i++) if (vld[i] && rdy[i]) m_a = i;
      if (m_a >= 0) begin
        m_it.prod = 32'(longint'(da[m_a*16 +: 16]) * longint'(db[m_a*16 +: 16]));
        m_it.id = m_a;
        m_it.edge_no = cyc + 1;
        sbq.push_back(m_it);
        ptr = (m_a + 1) % N;
        acc_id = m_a;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_id >= 0) vld[acc_id] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    vld[i] = 1'b1;
    da[i*16 +: 16] = a;
    db[i*16 +: 16] = b;
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic single(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string tag);
    set_req(i, a, b);
    rr = 1'b1;
    tick();
    check({tag, "_acc"}, acc_id, i);
    check({tag, "_rv_t"}, rv, 0);
    check({tag, "_busy_t"}, busy, 1);
    tick();
    check({tag, "_rv_t1"}, rv, 1);
    check({tag, "_result"}, res, exp);
    check({tag, "_id"}, rid, i);
    tick();
    check({tag, "_rv_done"}, rv, 0);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  int nacc;
  int resp0;

  initial begin
    repeat (3) tick();
    check("reset_valid", rv, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;

    single(0, 16'h0003, 16'h0005, 32'h0000000F, "basic");
    single(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "max");
    single(0, 16'h0000, 16'h1234, 32'h00000000, "zero");

    // Round robin from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rr = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 16'(i + 2), 16'(3 * i + 7));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_order", acc_id, k % N);
      if (k >= 1) check("rr_stream", rv, 1);
      if (k == 0) set_req(0, 16'h1111, 16'h0009);
    end
    repeat (3) tick();

    // Backpressure with three pending requests
    rr = 1'b0;
    set_req(0, 16'h0101, 16'h0002);
    set_req(1, 16'h0202, 16'h0003);
    set_req(2, 16'h0303, 16'h0004);
    nacc = 0;
    resp0 = n_resp;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (acc_id >= 0) nacc++;
    end
    check("bp_accepts", nacc, 2);
    check("bp_ready", rdy, '0);
    check("bp_valid", rv, 1);
    check("bp_pending", $countones(vld), 1);
    rr = 1'b1;
    repeat (6) tick();
    check("bp_drained", n_resp - resp0, 3);
    check("bp_busy", busy, 0);

    // Pointer moves past requester 2
    set_req(2, 16'h0010, 16'h0010);
    tick();
    check("ptr_first", acc_id, 2);
    set_req(1, 16'h0020, 16'h0003);
    set_req(3, 16'h0030, 16'h0005);
    tick();
    check("ptr_three", acc_id, 3);
    tick();
    check("ptr_one", acc_id, 1);
    repeat (3) tick();

    // Reset with both stages full
    for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom));
    rr = 1'b0;
    tick();
    tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", rv, 0);
    check("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom));
    rr = 1'b1;
    tick();
    check("mid_first_grant", acc_id, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 2) == 0) set_req(i, rand_op(), rand_op());
        else if (vld[i] && $urandom_range(0, 15) == 0) vld[i] = 1'b0;
      end
      rr = ($urandom_range(0, 3) != 0);
    end

    vld = '0;
    rr = 1'b1;
    repeat (6) tick();
    check("final_empty", sbq.size(), 0);
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
